power_cmd_sched: RTL and testbench
==================================

Name: power_cmd_sched

Overview:
Command scheduler that shares the power-amplifier UART command path between several on-chip requesters. It arbitrates requests round-robin and issues one 32-bit command to the UART transmit interface (send_en/send_data/send_vld). It then waits for the matching 40-bit reply (recieve_data/recirve_vld), with timeout and retry, and returns the reply or an error to the owning requester. It sits between the control logic (AGC, power monitor, host register bank) and the power UART top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
RSP_TIMEOUT, 2500000, clk cycles allowed from TX completion to reply (50 ms at 50 MHz)
TX_TIMEOUT, 50000, clk cycles allowed for send_vld to rise and then fall after send_en
MAX_RETRY, 2, re-sends after the first attempt before an error is reported

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  per-requester request level; held until ack
req_cmd  in  NUM_REQ*32  per-requester command; slice i = [32*i+31:32*i]; bits [31:24] = opcode
ack  out  NUM_REQ  one-cycle pulse: the requester's command has been latched
rsp_vld  out  NUM_REQ  one-cycle pulse: reply or error delivered to this requester
rsp_err  out  1  qualifies rsp_vld; 1 = timeout after all retries
rsp_data  out  40  reply word; valid in the rsp_vld cycle
send_en  out  1  to UART: one-cycle pulse starting a transmission
send_data  out  32  to UART: command word; stable from the send_en cycle to the end of the transaction
send_vld  in  1  from UART: high while transmitting
recieve_data  in  40  from UART: parsed reply
recirve_vld  in  1  from UART: reply strobe
busy  out  1  high in every state except IDLE
unsol_pulse  out  1  one-cycle pulse: reply dropped as unsolicited or mismatched

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; retry and timeout counters 0.
- IDLE: if any req bit is set, grant the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - In that same cycle: pulse ack[g], latch req_cmd slice g into send_data, store g, set pointer to g+1 (mod NUM_REQ), go to SEND.
  - Grant latency: ack appears 1 cycle after req is sampled high.
- SEND: if send_vld is 0, pulse send_en for 1 cycle, clear the timer, go to TX_WAIT_HI. If send_vld is 1, stay and do not pulse.
- TX_WAIT_HI: on send_vld=1 go to TX_WAIT_LO; on timer reaching TX_TIMEOUT, go to RETRY.
- TX_WAIT_LO: on send_vld=0, clear the timer and go to RX_WAIT; on timer reaching TX_TIMEOUT, go to RETRY.
- RX_WAIT: a reply matches when recirve_vld=1 and recieve_data[39:32] equals send_data[31:24].
  - Match: latch rsp_data, go to DONE.
  - Mismatch: pulse unsol_pulse and stay in RX_WAIT.
  - Timer reaching RSP_TIMEOUT: go to RETRY.
- RETRY: if the retry count is below MAX_RETRY, increment it and go to SEND with send_data unchanged. Otherwise go to ERR.
- DONE: pulse rsp_vld[g] with rsp_err=0; clear the retry count; go to IDLE.
- ERR: pulse rsp_vld[g] with rsp_err=1 and rsp_data=0; clear the retry count; go to IDLE.
- A new grant is never made in the DONE or ERR cycle. The minimum back-to-back spacing between acks is therefore one full transaction plus 1 IDLE cycle.
- recirve_vld in any state other than RX_WAIT pulses unsol_pulse; the reply is discarded.
- recirve_vld in the same cycle the RX_WAIT timer expires: the match wins.
- If req[g] drops after ack, the transaction still completes and rsp_vld is still delivered. A requester must not reassert req before it has received its own rsp_vld.
- Timers are saturating and sized clog2(max(RSP_TIMEOUT, TX_TIMEOUT))+1 bits. The expiry test is timer == limit-1, which gives exactly limit cycles.
- rst asserted mid-transaction aborts it: no rsp_vld is issued. send_en and all other outputs are low the next cycle. The UART may still finish its frame; its later reply raises unsol_pulse.

Decomposition:
- Package power_cmd_pkg holds:
  - the state encoding localparams (IDLE, SEND, TX_WAIT_HI, TX_WAIT_LO, RX_WAIT, RETRY, DONE, ERR);
  - the opcode field position constants OPC_HI=31 and OPC_LO=24;
  - the reply tag position constants RSP_TAG_HI=39 and RSP_TAG_LO=32.
- One sub-module, rr_arbiter (NUM_REQ-wide, pointer in, one-hot grant and index out, purely combinational), instantiated once. The FSM and timers stay in the top module.

Test Plan:
- Single request: req[1]=1, req_cmd[1]=32'hA5000012. Bench UART model raises send_vld 5 cycles after send_en, holds it 100 cycles, then returns 40'hA5_00000077. Required: ack[1] one cycle later; one send_en; rsp_vld[1] with rsp_err=0 and rsp_data=40'hA500000077.
- Fairness: req=4'b1111 held continuously, each transaction answered. Required: ack order 0,1,2,3,0; no requester granted twice before all four have been served.
- Timeout with retries: RSP_TIMEOUT=1000, MAX_RETRY=2, UART model never replies. Required: exactly 3 send_en pulses, each about 1000 cycles after TX completion; then rsp_vld with rsp_err=1 and rsp_data=0.
- Mismatch: command opcode 8'h3C; model first replies with tag 8'h11, then with tag 8'h3C. Required: unsol_pulse on the first reply; rsp_vld on the second only.
- Busy UART: send_vld already high when SEND is entered. Required: send_en delayed until send_vld falls; only one pulse.
- Reset in RX_WAIT: rst pulsed for 1 cycle; reply arrives afterwards. Required: no rsp_vld; busy=0 the cycle after rst; unsol_pulse when the late reply arrives.

Source files
------------

// File: rtl/power_cmd_pkg.sv
// Shared definitions for the power-amplifier UART command scheduler:
// FSM state encoding, command/reply field positions and a sizing helper.
package power_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    TX_WAIT_HI,
    TX_WAIT_LO,
    RX_WAIT,
    RETRY,
    DONE,
    ERR
  } state_e;

  localparam int OPC_HI     = 31;
  localparam int OPC_LO     = 24;
  localparam int RSP_TAG_HI = 39;
  localparam int RSP_TAG_LO = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/power_cmd_sched_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// after the pointer, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       valid_o
);

  localparam int IDXW = $clog2(NUM_REQ);

  logic [IDXW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDXW'((int'(ptr_i) + k) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/power_cmd_sched.sv
// Shares the power UART command path between NUM_REQ requesters: round-robin
// grant, one command per transaction, reply matching with timeout and retry.
module power_cmd_sched
  import power_cmd_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int RSP_TIMEOUT = 2500000,
  parameter int TX_TIMEOUT  = 50000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*32-1:0]   req_cmd,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      rsp_vld,
  output logic                    rsp_err,
  output logic [39:0]             rsp_data,
  output logic                    send_en,
  output logic [31:0]             send_data,
  input  logic                    send_vld,
  input  logic [39:0]             recieve_data,
  input  logic                    recirve_vld,
  output logic                    busy,
  output logic                    unsol_pulse
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int TW   = $clog2(max_int(RSP_TIMEOUT, TX_TIMEOUT)) + 1;
  localparam int RW   = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [TW-1:0] TX_LIM  = TW'(TX_TIMEOUT - 1);
  localparam logic [TW-1:0] RSP_LIM = TW'(RSP_TIMEOUT - 1);

  state_e              state_q;
  logic [TW-1:0]       timer_q, timerSat_d;
  logic [RW-1:0]       retryCnt_q;
  logic [IDXW-1:0]     grantIdx_q, rrPtr_q;
  logic [NUM_REQ-1:0]  ack_q, rspVld_q;
  logic                rspErr_q, sendEn_q, unsol_q;
  logic [39:0]         rspData_q;
  logic [31:0]         sendData_q, cmdSel;

  logic [NUM_REQ-1:0]  arbGrant;
  logic [IDXW-1:0]     arbIdx;
  logic                arbValid;
  logic                tagMatch;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (req),
    .ptr_i   (rrPtr_q),
    .grant_o (arbGrant),
    .idx_o   (arbIdx),
    .valid_o (arbValid)
  );

  always_comb begin
    cmdSel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arbGrant[i]) cmdSel = req_cmd[i*32 +: 32];
    end
  end

  assign timerSat_d = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
  assign tagMatch   = recieve_data[RSP_TAG_HI:RSP_TAG_LO] == sendData_q[OPC_HI:OPC_LO];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      retryCnt_q <= '0;
      grantIdx_q <= '0;
      rrPtr_q    <= '0;
      ack_q      <= '0;
      rspVld_q   <= '0;
      rspErr_q   <= 1'b0;
      rspData_q  <= '0;
      sendEn_q   <= 1'b0;
      sendData_q <= '0;
      unsol_q    <= 1'b0;
    end else begin
      ack_q    <= '0;
      rspVld_q <= '0;
      rspErr_q <= 1'b0;
      sendEn_q <= 1'b0;
      unsol_q  <= 1'b0;
      // Replies outside RX_WAIT have no owner and are simply dropped.
      if (recirve_vld && state_q != RX_WAIT) unsol_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (arbValid) begin
            ack_q      <= arbGrant;
            sendData_q <= cmdSel;
            grantIdx_q <= arbIdx;
            rrPtr_q    <= (arbIdx == IDXW'(NUM_REQ - 1)) ? '0 : arbIdx + 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (!send_vld) begin
            sendEn_q <= 1'b1;
            timer_q  <= '0;
            state_q  <= TX_WAIT_HI;
          end
        end
        TX_WAIT_HI: begin
          timer_q <= timerSat_d;
          if (send_vld)                state_q <= TX_WAIT_LO;
          else if (timer_q == TX_LIM)  state_q <= RETRY;
        end
        TX_WAIT_LO: begin
          if (!send_vld) begin
            timer_q <= '0;
            state_q <= RX_WAIT;
          end else begin
            timer_q <= timerSat_d;
            if (timer_q == TX_LIM) state_q <= RETRY;
          end
        end
        RX_WAIT: begin
          // A matching reply beats a timer expiring in the same cycle.
          if (recirve_vld && tagMatch) begin
            rspData_q <= recieve_data;
            state_q   <= DONE;
          end else begin
            if (recirve_vld) unsol_q <= 1'b1;
            timer_q <= timerSat_d;
            if (timer_q == RSP_LIM) state_q <= RETRY;
          end
        end
        RETRY: begin
          if (retryCnt_q < RW'(MAX_RETRY)) begin
            retryCnt_q <= retryCnt_q + 1'b1;
            state_q    <= SEND;
          end else begin
            state_q <= ERR;
          end
        end
        DONE: begin
          rspVld_q[grantIdx_q] <= 1'b1;
          retryCnt_q           <= '0;
          state_q              <= IDLE;
        end
        ERR: begin
          rspVld_q[grantIdx_q] <= 1'b1;
          rspErr_q             <= 1'b1;
          rspData_q            <= '0;
          retryCnt_q           <= '0;
          state_q              <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign rsp_vld     = rspVld_q;
  assign rsp_err     = rspErr_q;
  assign rsp_data    = rspData_q;
  assign send_en     = sendEn_q;
  assign send_data   = sendData_q;
  assign unsol_pulse = unsol_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_power_cmd_sched.sv
// Bench for power_cmd_sched: UART model, vector table, corner-case sequences
// and randomized round-robin traffic checked against a reference model.
module tb_power_cmd_sched;

  localparam int NUM_REQ       = 4;
  localparam int RSP_TIMEOUT   = 1000;
  localparam int TX_TIMEOUT    = 300;
  localparam int MAX_RETRY     = 2;
  localparam int TX_DELAY      = 5;
  localparam int MODE_NORMAL   = 0;
  localparam int MODE_NEVER    = 1;
  localparam int MODE_MISMATCH = 2;
  localparam int BUDGET        = 6000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*32-1:0] reqCmd;
  logic [NUM_REQ-1:0]    ack, rspVld;
  logic                  rspErr, sendEn, busy, unsolPulse;
  logic [39:0]           rspData, recvData;
  logic [31:0]           sendData, uartCmd;
  logic                  sendVldModel, busyOverride, recvVld;
  logic                  sendVld;

  assign sendVld = sendVldModel | busyOverride;

  always #5 clk = ~clk;

  power_cmd_sched #(
    .NUM_REQ(NUM_REQ), .RSP_TIMEOUT(RSP_TIMEOUT),
    .TX_TIMEOUT(TX_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(reqCmd),
    .ack(ack), .rsp_vld(rspVld), .rsp_err(rspErr), .rsp_data(rspData),
    .send_en(sendEn), .send_data(sendData), .send_vld(sendVld),
    .recieve_data(recvData), .recirve_vld(recvVld),
    .busy(busy), .unsol_pulse(unsolPulse)
  );

  int checks = 0, failures = 0, cycle = 0;
  int sendEnCount = 0, unsolCount = 0, rspCount = 0;
  int sendEnTimes[$];
  int txHold, rxDelay, replyMode;
  int modelPtr, gotIdx, expIdx, se0, un0, rsp0;
  bit gotOk;
  logic gotErr;
  logic [39:0] gotData;
  logic [3:0] remaining;
  logic [31:0] roundCmds [4];

  typedef struct {
    int          idx;
    logic [31:0] cmd;
    int          mode;
    int          hold;
    int          rxd;
    logic        expErr;
    logic [39:0] expData;
    int          expSendEn;
    int          expUnsol;
  } vec_t;
  vec_t vecs [5];

  // Output monitor: event counters and send_en timestamps
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (sendEn) begin sendEnCount++; sendEnTimes.push_back(cycle); end
      if (unsolPulse) unsolCount++;
      if (rspVld != '0) rspCount++;
    end
  end

  // UART model: raises send_vld TX_DELAY cycles after send_en, holds it,
  // then replies with {opcode, 8'h00, cmd[23:0]^24'h65} according to replyMode
  initial begin
    sendVldModel = 1'b0; recvVld = 1'b0; recvData = '0; uartCmd = '0;
    forever begin
      @(negedge clk);
      if (sendEn) begin
        uartCmd = sendData;
        repeat (TX_DELAY) @(negedge clk);
        sendVldModel = 1'b1;
        repeat (txHold) @(negedge clk);
        sendVldModel = 1'b0;
        if (replyMode != MODE_NEVER) begin
          repeat (rxDelay) @(negedge clk);
          if (replyMode == MODE_MISMATCH) begin
            recvData = {8'h11, 32'h5A5A5A5A}; recvVld = 1'b1;
            @(negedge clk);
            recvVld = 1'b0;
            repeat (4) @(negedge clk);
          end
          recvData = {uartCmd[31:24], 8'h00, uartCmd[23:0] ^ 24'h000065};
          recvVld  = 1'b1;
          @(negedge clk);
          recvVld = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [39:0] expReply(input logic [31:0] cmd);
    return {cmd[31:24], 8'h00, cmd[23:0] ^ 24'h000065};
  endfunction

  function automatic int onehotIdx(input logic [3:0] v);
    if ($countones(v) != 1) return -2;
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -2;
  endfunction

  // Round-robin reference: first pending requester at or after the pointer
  function automatic int modelPick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] cmd);
    reqCmd[idx*32 +: 32] = cmd;
    req[idx] = 1'b1;
  endtask

  task automatic waitAck(output int idx, output bit ok);
    ok = 1'b0; idx = -1;
    for (int i = 0; i < BUDGET; i++) begin
      step();
      if (ack != '0) begin ok = 1'b1; idx = onehotIdx(ack); break; end
    end
    checkOutput("ack_arrived", 64'(ok), 64'd1);
  endtask

  task automatic waitRsp(output int idx, output bit ok, output logic err, output logic [39:0] data);
    ok = 1'b0; idx = -1; err = 1'bx; data = 'x;
    for (int i = 0; i < BUDGET; i++) begin
      step();
      if (rspVld != '0) begin
        ok = 1'b1; idx = onehotIdx(rspVld); err = rspErr; data = rspData;
        break;
      end
    end
    checkOutput("rsp_arrived", 64'(ok), 64'd1);
  endtask

  initial begin
    req = '0; reqCmd = '0; rst = 1'b1; busyOverride = 1'b0;
    txHold = 100; rxDelay = 10; replyMode = MODE_NORMAL;

    vecs[0] = '{1, 32'hA5000012, MODE_NORMAL,   100, 10,   1'b0, 40'hA500000077, 1, 0};
    vecs[1] = '{2, 32'h3C00ABCD, MODE_MISMATCH, 20,  10,   1'b0, 40'h3C0000ABA8, 1, 1};
    vecs[2] = '{0, 32'h7E123456, MODE_NEVER,    100, 10,   1'b1, 40'h0,          3, 0};
    vecs[3] = '{3, 32'hC3FF0001, MODE_NORMAL,   20,  1000, 1'b0, 40'hC300FF0064, 1, 0};
    vecs[4] = '{1, 32'h01020304, MODE_NORMAL,   1,   1,    1'b0, 40'h0100020361, 1, 0};

    repeat (3) step();
    checkOutput("reset_ack",       64'(ack),        64'd0);
    checkOutput("reset_rsp_vld",   64'(rspVld),     64'd0);
    checkOutput("reset_rsp_err",   64'(rspErr),     64'd0);
    checkOutput("reset_rsp_data",  64'(rspData),    64'd0);
    checkOutput("reset_send_en",   64'(sendEn),     64'd0);
    checkOutput("reset_send_data", 64'(sendData),   64'd0);
    checkOutput("reset_busy",      64'(busy),       64'd0);
    checkOutput("reset_unsol",     64'(unsolPulse), 64'd0);
    rst = 1'b0;
    modelPtr = 0;
    step();

    $display("[TB] vector table");
    foreach (vecs[v]) begin
      txHold = vecs[v].hold; rxDelay = vecs[v].rxd; replyMode = vecs[v].mode;
      se0 = sendEnCount; un0 = unsolCount;
      sendEnTimes.delete();
      applyStimulus(vecs[v].idx, vecs[v].cmd);
      step();
      checkOutput("ack_latency", 64'(ack), 64'd1 << vecs[v].idx);
      req[vecs[v].idx] = 1'b0;
      modelPtr = (vecs[v].idx + 1) % NUM_REQ;
      waitRsp(gotIdx, gotOk, gotErr, gotData);
      checkOutput("rsp_idx",  64'(gotIdx),  64'(vecs[v].idx));
      checkOutput("rsp_err",  64'(gotErr),  64'(vecs[v].expErr));
      checkOutput("rsp_data", 64'(gotData), 64'(vecs[v].expData));
      repeat (3) step();
      checkOutput("send_en_count", 64'(sendEnCount - se0), 64'(vecs[v].expSendEn));
      checkOutput("unsol_count",   64'(unsolCount - un0),  64'(vecs[v].expUnsol));
      if (vecs[v].mode == MODE_NEVER) begin
        for (int i = 1; i < sendEnTimes.size(); i++)
          checkOutput("retry_gap", 64'(sendEnTimes[i] - sendEnTimes[i-1]),
                      64'(TX_DELAY + vecs[v].hold + RSP_TIMEOUT + 3));
      end
    end

    $display("[TB] busy UART");
    txHold = 10; rxDelay = 5; replyMode = MODE_NORMAL;
    busyOverride = 1'b1;
    se0 = sendEnCount;
    applyStimulus(2, 32'h5A001234);
    step();
    checkOutput("busy_ack", 64'(ack), 64'b0100);
    req[2] = 1'b0;
    modelPtr = 3;
    repeat (20) step();
    checkOutput("busy_no_send_en", 64'(sendEnCount - se0), 64'd0);
    busyOverride = 1'b0;
    waitRsp(gotIdx, gotOk, gotErr, gotData);
    checkOutput("busy_rsp_idx",  64'(gotIdx),  64'd2);
    checkOutput("busy_rsp_data", 64'(gotData), 64'h5A00001251);
    step();
    checkOutput("busy_send_en_count", 64'(sendEnCount - se0), 64'd1);

    $display("[TB] reset in RX_WAIT");
    txHold = 10; rxDelay = 40; replyMode = MODE_NORMAL;
    rsp0 = rspCount; un0 = unsolCount;
    applyStimulus(0, 32'h66000042);
    step();
    checkOutput("rst_ack", 64'(ack), 64'b0001);
    req[0] = 1'b0;
    repeat (25) step();
    checkOutput("rst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_busy_after",    64'(busy),   64'd0);
    checkOutput("rst_send_en_after", 64'(sendEn), 64'd0);
    modelPtr = 0;
    repeat (60) step();
    checkOutput("rst_no_rsp",     64'(rspCount - rsp0), 64'd0);
    checkOutput("rst_late_unsol", 64'(unsolCount - un0), 64'd1);

    $display("[TB] fairness");
    txHold = 5; rxDelay = 3; replyMode = MODE_NORMAL;
    for (int i = 0; i < 4; i++) roundCmds[i] = {8'h20 + 8'(i), 16'h0000, 8'(i * 16 + 3)};
    for (int i = 0; i < 4; i++) applyStimulus(i, roundCmds[i]);
    for (int n = 0; n < 5; n++) begin
      waitAck(gotIdx, gotOk);
      if (n == 4) req = '0;
      expIdx = modelPick(4'b1111, modelPtr);
      checkOutput("fair_order", 64'(gotIdx), 64'(expIdx));
      modelPtr = (expIdx + 1) % NUM_REQ;
      if (!gotOk) break;
      waitRsp(gotIdx, gotOk, gotErr, gotData);
      checkOutput("fair_rsp_idx",  64'(gotIdx),  64'(expIdx));
      checkOutput("fair_rsp_data", 64'(gotData), 64'(expReply(roundCmds[expIdx])));
    end
    repeat (3) step();

    $display("[TB] randomized rounds");
    for (int r = 0; r < 6; r++) begin
      txHold = $urandom_range(1, 8); rxDelay = $urandom_range(1, 8);
      remaining = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        roundCmds[i] = $urandom;
        if (remaining[i]) applyStimulus(i, roundCmds[i]);
      end
      for (int n = 0; n < 4 && remaining != '0; n++) begin
        waitAck(gotIdx, gotOk);
        expIdx = modelPick(remaining, modelPtr);
        checkOutput("rand_grant", 64'(gotIdx), 64'(expIdx));
        remaining[expIdx] = 1'b0;
        req[expIdx] = 1'b0;
        if (gotIdx >= 0) req[gotIdx] = 1'b0;
        modelPtr = (expIdx + 1) % NUM_REQ;
        if (!gotOk) break;
        waitRsp(gotIdx, gotOk, gotErr, gotData);
        checkOutput("rand_rsp_idx",  64'(gotIdx),  64'(expIdx));
        checkOutput("rand_rsp_err",  64'(gotErr),  64'd0);
        checkOutput("rand_rsp_data", 64'(gotData), 64'(expReply(roundCmds[expIdx])));
      end
      req = '0;
      repeat (3) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
